// File: rtl/bus_sched.sv
// bus_sched: four-master round-robin bus scheduler with quantum preemption.
// Define BUS_SCHED_WDT_EN to build the transaction watchdog (ABORT, to_rdy_, bus_err, err_owner).
module bus_sched #(
   parameter int QUANTUM = 16,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   input  logic       s_as_,
   input  logic       m_rdy_,
   output logic [1:0] owner,
   output logic       owner_vld,
   output logic       to_rdy_,
   output logic       bus_err,
   output logic [1:0] err_owner,
   input  logic       err_clr
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, ABORT} state_t;

   state_t     state, state_nxt;
   logic [3:0] req;
   logic [3:0] grnt_n;
   logic [1:0] last_owner;
   logic [1:0] winner;
   logic [7:0] qcnt;
   logic       owner_req;
   logic       others_req;
   logic       q_full;
   logic       wdt_limit;
   logic       do_grant;
   logic       do_drop;

   // First requester found scanning last_owner+1 .. last_owner+4 (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign winner     = rr_pick(req, last_owner);
   assign owner_req  = req[owner];
   assign others_req = |(req & ~(4'b0001 << owner));
   assign q_full     = (qcnt == 8'(QUANTUM));

   assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;

   // NOTE: the asynchronous reset releases every grant at once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_drop   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               do_grant  = 1'b1;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!s_as_) begin
               state_nxt = BUSY;
            end else if (!owner_req) begin
               if (others_req) begin
                  do_grant = 1'b1;
               end else begin
                  do_drop   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (q_full && others_req) begin
               do_grant = 1'b1;
            end
         end
         // The grant is held through BUSY even if the owner drops its request.
         BUSY: begin
            if (!m_rdy_)        state_nxt = GRANT;
            else if (wdt_limit) state_nxt = ABORT;
         end
         ABORT:   state_nxt = GRANT;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, owner and round-robin pointer move together, so handover is glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grnt_n     <= 4'hF;
         owner      <= 2'd0;
         owner_vld  <= 1'b0;
         last_owner <= 2'd3;
         qcnt       <= 8'd0;
      end else if (do_grant) begin
         grnt_n     <= ~(4'b0001 << winner);
         owner      <= winner;
         owner_vld  <= 1'b1;
         last_owner <= winner;
         qcnt       <= 8'd0;
      end else if (do_drop) begin
         grnt_n    <= 4'hF;
         owner_vld <= 1'b0;
      end else if ((state == GRANT || state == BUSY) && !q_full) begin
         qcnt <= qcnt + 8'd1;
      end
   end

`ifdef BUS_SCHED_WDT_EN
   logic [7:0] wcnt;
   logic       abort_enter;

   assign wdt_limit   = (wcnt == 8'(TIMEOUT - 1));
   assign abort_enter = (state == BUSY) && m_rdy_ && wdt_limit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt <= 8'd0;
      end else if (state == GRANT && !s_as_) begin
         wcnt <= 8'd0;
      end else if (state == BUSY) begin
         wcnt <= wcnt + 8'd1;
      end
   end

   // Capturing the culprit wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             err_owner <= 2'd0;
      else if (abort_enter) err_owner <= owner;
      else if (err_clr)     err_owner <= 2'd0;
   end

   always_comb begin
      to_rdy_ = 1'b1;
      bus_err = 1'b0;
      if (state == ABORT) begin
         to_rdy_ = 1'b0;
         bus_err = 1'b1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT;
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign wdt_limit      = 1'b0;
   assign to_rdy_        = 1'b1;
   assign bus_err        = 1'b0;
   assign err_owner      = 2'd0;
`endif

endmodule

// File: tb/tb_bus_sched.sv
// tb_bus_sched: vector table, hand-written corner sequences and a randomized run
// against a cycle-level reference model of the scheduling rules.
module tb_bus_sched;

   localparam int Q = 4;
   localparam int T = 8;
`ifdef BUS_SCHED_WDT_EN
   localparam bit WDT = 1'b1;
`else
   localparam bit WDT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_n;
   logic       s_as_;
   logic       m_rdy_;
   logic       err_clr;
   wire  [3:0] grnt_n;
   wire  [1:0] owner;
   wire        owner_vld;
   wire        to_rdy_;
   wire        bus_err;
   wire  [1:0] err_owner;

   int n_cmp = 0;
   int n_bad = 0;

   bus_sched #(.QUANTUM(Q), .TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req_   (req_n[0]),
      .m1_req_   (req_n[1]),
      .m2_req_   (req_n[2]),
      .m3_req_   (req_n[3]),
      .m0_grnt_  (grnt_n[0]),
      .m1_grnt_  (grnt_n[1]),
      .m2_grnt_  (grnt_n[2]),
      .m3_grnt_  (grnt_n[3]),
      .s_as_     (s_as_),
      .m_rdy_    (m_rdy_),
      .owner     (owner),
      .owner_vld (owner_vld),
      .to_rdy_   (to_rdy_),
      .bus_err   (bus_err),
      .err_owner (err_owner),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      req_n   = 4'hF;
      s_as_   = 1'b1;
      m_rdy_  = 1'b1;
      err_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [3:0] req;
      logic       as_n;
      logic       rdy_n;
      logic [3:0] grnt_n;
      logic [1:0] owner;
      logic       vld;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] r, input logic a, input logic y,
                               input logic [3:0] g, input logic [1:0] o, input logic v);
      mk = '{req: r, as_n: a, rdy_n: y, grnt_n: g, owner: o, vld: v};
   endfunction

   // ---------------- reference model ----------------
   int m_owner, m_last, m_held, m_wait, m_err;
   bit m_have, m_txn, m_abort;

   function automatic int pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return last;
   endfunction

   task automatic model_reset();
      m_owner = 0; m_last = 3; m_held = 0; m_wait = 0; m_err = 0;
      m_have = 0; m_txn = 0; m_abort = 0;
   endtask

   task automatic grant_to(input int c);
      m_owner = c; m_last = c; m_held = 0; m_have = 1;
   endtask

   // r/as/rdy/clr are active-high "asserted" views of the bus inputs before the edge.
   task automatic model_step(input logic [3:0] r, input bit as, input bit rdy, input bit clr);
      logic [3:0] mask;
      bit others, enter_abort;
      mask        = 4'b0001 << m_owner;
      others      = |(r & ~mask);
      enter_abort = 0;
      if (m_abort) begin
         m_abort = 0;
      end else if (!m_have) begin
         if (|r) grant_to(pick(r, m_last));
      end else if (!m_txn) begin
         if (as) begin
            m_txn = 1; m_wait = 0;
            if (m_held < Q) m_held++;
         end else if (!r[m_owner]) begin
            if (others) grant_to(pick(r, m_last));
            else m_have = 0;
         end else if (m_held == Q && others) begin
            grant_to(pick(r, m_last));
         end else if (m_held < Q) begin
            m_held++;
         end
      end else begin
         if (m_held < Q) m_held++;
         if (rdy) m_txn = 0;
         else if (WDT && m_wait == T - 1) begin
            m_txn = 0; m_abort = 1; enter_abort = 1;
         end else m_wait++;
      end
      if (enter_abort) m_err = m_owner;
      else if (clr && WDT) m_err = 0;
   endtask

   initial begin
      vec_t       vecs[13];
      logic [3:0] r;
      logic [3:0] mask;
      logic [3:0] eg;
      bit         as, rdy, clr;
      int         cur;

      // ---- reset state ----
      do_reset();
      check("rst_grnt", grnt_n, 4'hF);
      check("rst_owner", owner, 2'd0);
      check("rst_vld", owner_vld, 1'b0);
      check("rst_to_rdy", to_rdy_, 1'b1);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_err_owner", err_owner, 2'd0);

      // ---- table: m0+m2 start, handover, drop, BUSY hold, release ----
      vecs[0]  = mk(4'b0101, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1);
      vecs[1]  = mk(4'b0100, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1);
      vecs[2]  = mk(4'b0100, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1);
      vecs[3]  = mk(4'b0000, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0);
      vecs[4]  = mk(4'b0000, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0);
      vecs[5]  = mk(4'b1000, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
      vecs[6]  = mk(4'b1010, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
      vecs[7]  = mk(4'b1010, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
      vecs[8]  = mk(4'b1010, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b1);
      vecs[9]  = mk(4'b0010, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b1);
      vecs[10] = mk(4'b0010, 1'b1, 1'b0, 4'b0111, 2'd3, 1'b1);
      vecs[11] = mk(4'b0010, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1);
      vecs[12] = mk(4'b0000, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0);
      for (int i = 0; i < 13; i++) begin
         req_n  = ~vecs[i].req;
         s_as_  = vecs[i].as_n;
         m_rdy_ = vecs[i].rdy_n;
         tick();
         check($sformatf("vec%0d_grnt", i), grnt_n, vecs[i].grnt_n);
         check($sformatf("vec%0d_owner", i), owner, vecs[i].owner);
         check($sformatf("vec%0d_vld", i), owner_vld, vecs[i].vld);
      end

      // ---- all four requesting, one transaction each: order 0,1,2,3,0 ----
      do_reset();
      req_n = 4'h0;
      tick();
      check("rr_first", {grnt_n, owner}, {4'b1110, 2'd0});
      for (int k = 0; k < 4; k++) begin
         cur = k;
         s_as_ = 1'b0; tick();
         s_as_ = 1'b1; m_rdy_ = 1'b0; tick();
         m_rdy_ = 1'b1; req_n[cur] = 1'b1; tick();
         mask = 4'b0001 << ((cur + 1) % 4);
         check($sformatf("rr_next%0d", k), {grnt_n, owner}, {~mask, 2'((cur + 1) % 4)});
         req_n[cur] = 1'b0;
      end

      // ---- quantum preemption: m1 idles on the bus, m3 waits ----
      do_reset();
      req_n = ~4'b0010;
      tick();
      check("q_m1_grant", grnt_n, 4'b1101);
      req_n = ~4'b1010;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("q_hold%0d", k), grnt_n, 4'b1101);
      end
      tick();
      check("q_preempt", {grnt_n, owner}, {4'b0111, 2'd3});

`ifdef BUS_SCHED_WDT_EN
      // ---- watchdog timeout on m2 ----
      do_reset();
      req_n = ~4'b0100;
      tick();
      s_as_ = 1'b0; tick();
      s_as_ = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check($sformatf("wd_wait%0d", k), {to_rdy_, bus_err}, 2'b10);
      end
      tick();
      check("wd_abort", {to_rdy_, bus_err, err_owner, grnt_n}, {1'b0, 1'b1, 2'd2, 4'b1011});
      tick();
      check("wd_after", {to_rdy_, bus_err, err_owner, grnt_n}, {1'b1, 1'b0, 2'd2, 4'b1011});
      repeat (3) tick();
      check("wd_sticky", err_owner, 2'd2);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("wd_clr", err_owner, 2'd0);

      // ---- completion in the limit cycle beats the watchdog ----
      do_reset();
      req_n = ~4'b0100;
      tick();
      s_as_ = 1'b0; tick();
      s_as_ = 1'b1;
      repeat (7) tick();
      m_rdy_ = 1'b0; tick();
      check("wd_race", {to_rdy_, bus_err, err_owner, grnt_n}, {1'b1, 1'b0, 2'd0, 4'b1011});
      m_rdy_ = 1'b1; tick();
      check("wd_race_after", {to_rdy_, bus_err}, 2'b10);
`else
      // ---- no watchdog: a stalled transaction keeps its grant ----
      do_reset();
      req_n = ~4'b0100;
      tick();
      s_as_ = 1'b0; tick();
      s_as_ = 1'b1;
      err_clr = 1'b1;
      for (int k = 0; k < 300; k++) begin
         tick();
         check($sformatf("stall%0d", k), {grnt_n, to_rdy_, bus_err, err_owner},
               {4'b1011, 1'b1, 1'b0, 2'd0});
      end
      err_clr = 1'b0;
      m_rdy_ = 1'b0; tick(); m_rdy_ = 1'b1;
      check("stall_done", grnt_n, 4'b1011);
`endif

      // ---- reset in the middle of a transaction ----
      do_reset();
      req_n = ~4'b0100;
      tick();
      s_as_ = 1'b0; tick();
      s_as_ = 1'b1;
      repeat (2) tick();
      #1 rst = 1'b0;
      #1 check("arst_grnt", {grnt_n, owner_vld, bus_err, to_rdy_}, {4'hF, 1'b0, 1'b0, 1'b1});
      repeat (2) @(negedge clk);
      check("arst_hold", {grnt_n, bus_err}, {4'hF, 1'b0});

      // ---- randomized run against the reference model ----
      do_reset();
      model_reset();
      r = 4'h0;
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 99) < 20) r[b] = ~r[b];
         as  = ($urandom_range(0, 99) < 25);
         rdy = ($urandom_range(0, 99) < (((n / 250) % 2) ? 3 : 35));
         clr = ($urandom_range(0, 99) < 5);
         req_n = ~r; s_as_ = ~as; m_rdy_ = ~rdy; err_clr = clr;
         @(posedge clk);
         model_step(r, as, rdy, clr);
         @(negedge clk);
         mask = 4'b0001 << m_owner;
         eg   = m_have ? ~mask : 4'hF;
         check($sformatf("rand%0d", n),
               {grnt_n, owner, owner_vld, to_rdy_, bus_err, err_owner},
               {eg, 2'(m_owner), m_have, ~m_abort, m_abort, 2'(m_err)});
         check($sformatf("rand%0d_onehot", n), ($countones(~grnt_n) <= 1), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
